// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, valid and framing-error strobes.
// Optional even-parity bit between data and stop, enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        rx_clk,
  input  logic        RST,
  input  logic        rx_input,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        rx_frame_err,
  output logic        rx_parity_err,
  output logic [15:0] clk_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic             sync_q1;
  logic             rx_sync;
  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] count_n;
  logic [7:0]       shift, shift_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       data_n;
  logic             valid_n;
  logic             ferr_n;
  logic             busy_n;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_n;
  logic             perr_n;
`endif

  // Two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge rx_clk) begin
    if (RST) begin
      sync_q1 <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync_q1 <= rx_input;
      rx_sync <= sync_q1;
    end
  end

  // State and datapath registers
  always_ff @(posedge rx_clk) begin
    if (RST) begin
      state        <= S_IDLE;
      clk_count    <= '0;
      shift        <= '0;
      bit_idx      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      clk_count    <= count_n;
      shift        <= shift_n;
      bit_idx      <= bit_idx_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= ferr_n;
      rx_busy      <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_bad       <= par_bad_n;
      rx_parity_err <= perr_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

  // Next-state and next-output logic; samples are taken at bit-period wrap
  always_comb begin
    state_n   = state;
    count_n   = clk_count;
    shift_n   = shift;
    bit_idx_n = bit_idx;
    data_n    = rx_data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        count_n = '0;
        if (!rx_sync) state_n = S_START;
      end
      S_START: begin
        if (clk_count == HALF) begin
          count_n   = '0;
          bit_idx_n = '0;
          // A line back high at mid-start is a glitch, not a frame
          state_n   = rx_sync ? S_IDLE : S_DATA;
        end else begin
          count_n = clk_count + 16'd1;
        end
      end
      S_DATA: begin
        if (clk_count == LAST) begin
          count_n = '0;
          shift_n = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          count_n = clk_count + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_count == LAST) begin
          count_n   = '0;
          // Even parity: data bits plus parity bit must XOR to zero
          par_bad_n = (^shift) ^ rx_sync;
          state_n   = S_STOP;
        end else begin
          count_n = clk_count + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (clk_count == LAST) begin
          count_n = '0;
          if (rx_sync) begin
            state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              perr_n = 1'b1;
            end else begin
              data_n  = shift;
              valid_n = 1'b1;
            end
`else
            data_n  = shift;
            valid_n = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = S_WAIT;
          end
        end else begin
          count_n = clk_count + 16'd1;
        end
      end
      S_WAIT: begin
        // Hold through a break so it yields a single error strobe
        count_n = '0;
        if (rx_sync) state_n = S_IDLE;
      end
      default: begin
        count_n = '0;
        state_n = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

endmodule
